// File: rtl/dif_cmd_pkg.sv
// Shared types and line levels for the DIF serial command transmitter.
package dif_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;
  localparam int   CMD_W     = 4;

endpackage

// File: rtl/dif_cmd_tx_bit_tick.sv
// Bit-period timer: pulses tick on the last cycle of every B-cycle bit period.
module dif_bit_tick #(
  parameter int B = 4
) (
  input  logic Clk,
  input  logic Rst_N,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (B > 1) ? $clog2(B) : 1;
  localparam logic [W-1:0] LAST = W'(B - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/dif_cmd_tx.sv
// Framed serial command transmitter: start, 4 data bits MSB first, optional parity, stop.
// Parity bit is built in when DIF_CMD_PARITY_EN is defined.
module dif_cmd_tx
  import dif_cmd_pkg::*;
#(
  parameter int BIT_DIV = 4,
  parameter int CMD_W   = dif_cmd_pkg::CMD_W
) (
  input  logic             Clk,
  input  logic             Rst_N,
  input  logic [CMD_W-1:0] Cmd_Data,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  output logic             Ser_Out,
  output logic             Busy,
  output logic             Frame_Done
);

  state_e           state, state_nxt;
  logic [CMD_W-1:0] shreg, shreg_nxt;
  logic [1:0]       idx, idx_nxt, idx_dec;
  logic             ser_nxt, done_nxt;
  logic             tick, clr;

  assign Cmd_Ready = (state == IDLE);
  assign Busy      = (state != IDLE);
  assign idx_dec   = idx - 2'd1;

  dif_bit_tick #(.B(BIT_DIV)) u_tick (
    .Clk   (Clk),
    .Rst_N (Rst_N),
    .clr   (clr),
    .en    (Busy),
    .tick  (tick)
  );

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      Ser_Out    <= IDLE_LVL;
      Frame_Done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      idx        <= idx_nxt;
      Ser_Out    <= ser_nxt;
      Frame_Done <= done_nxt;
    end
  end

  // Ser_Out is registered, so each branch loads the level of the bit that starts next.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    idx_nxt   = idx;
    ser_nxt   = Ser_Out;
    done_nxt  = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        ser_nxt = IDLE_LVL;
        if (Cmd_Valid) begin
          state_nxt = START;
          shreg_nxt = Cmd_Data;
          idx_nxt   = '0;
          ser_nxt   = START_LVL;
          clr       = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
          idx_nxt   = idx_dec;
          ser_nxt   = shreg[idx_dec];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == 2'd0) begin
`ifdef DIF_CMD_PARITY_EN
            state_nxt = PARITY;
            ser_nxt   = ^shreg;
`else
            state_nxt = STOP;
            ser_nxt   = STOP_LVL;
`endif
          end else begin
            idx_nxt = idx_dec;
            ser_nxt = shreg[idx_dec];
          end
        end
      end
`ifdef DIF_CMD_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_nxt = STOP;
          ser_nxt   = STOP_LVL;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          ser_nxt   = IDLE_LVL;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        ser_nxt   = IDLE_LVL;
      end
    endcase
  end

endmodule
